// File: rtl/nios2_system_sysid_pkg.sv
// -----------------------------------------------------------------------------
// nios2_system_sysid_pkg
//
// Shared definitions for the system-ID slave and its checker:
//   - sysid_state_e    : checker FSM states
//   - SYSID_ADDR_ID/TS : word addresses of the ID and timestamp registers
//   - SYSID_DEFAULT_*  : expected ID / timestamp of the current build, used by
//                        both the slave generator and the checker defaults
// -----------------------------------------------------------------------------
package nios2_system_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1619612925;

endpackage : nios2_system_sysid_pkg

// File: rtl/nios2_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// nios2_system_sysid_checker
//
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = timestamp), compares both words with the expected build values and
// reports the result. Used to confirm the FPGA image matches the software
// build before the CPU is released.
//
// Optional build macro: SYSID_CHECK_TIMEOUT_EN
//   When defined, a 16-bit stall counter abandons a read that has been held
//   off by waitrequest for TIMEOUT_CYCLES cycles and raises 'timeout'.
//   When undefined, 'timeout' is tied 0 and a stuck slave hangs the check.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   start            in   single-cycle check request, ignored while busy
//   avm_address      out  word address (0 = ID, 1 = timestamp), registered
//   avm_read         out  Avalon read strobe, registered
//   avm_readdata     in   slave read data (sampled when waitrequest = 0)
//   avm_waitrequest  in   slave stall
//   busy             out  check in progress
//   done             out  check complete, held until the next start
//   pass             out  id_ok & ts_ok, valid while done = 1
//   id_ok / ts_ok    out  captured word equals its expected value
//   id_value         out  captured ID word
//   ts_value         out  captured timestamp word
//   timeout          out  read abandoned on waitrequest timeout
// -----------------------------------------------------------------------------
module nios2_system_sysid_checker
    import nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXP_TIMESTAMP  = SYSID_DEFAULT_TIMESTAMP,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout
);

    // Legal range is 1..65535; an out-of-range value is caught here at
    // elaboration by a visible named block in the hierarchy.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
    end

    sysid_state_e state_q, state_d;
    logic         auto_start_q, auto_start_d;
    logic         avm_read_q, avm_read_d;
    logic         avm_address_q, avm_address_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;
    logic         timeout_q, timeout_d;
    logic         stall_limit_hit;
    logic         id_match;
    logic         ts_match;

    assign id_match = (avm_readdata == EXP_ID);
    assign ts_match = (avm_readdata == EXP_TIMESTAMP);

`ifdef SYSID_CHECK_TIMEOUT_EN
    // Abort at the end of the TIMEOUT_CYCLES-th stalled cycle. A release
    // (waitrequest = 0) in that same cycle takes the normal capture path.
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_limit_hit = avm_read_q && avm_waitrequest && (stall_cnt_q == STALL_LIMIT);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_d != state_q) begin
            stall_cnt_d = 16'd0;
        end else if (avm_read_q && avm_waitrequest) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall_limit_hit = 1'b0;
`endif

    // Next-state and capture logic.
    always_comb begin
        state_d       = state_q;
        auto_start_d  = auto_start_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        done_d        = done_q;
        pass_d        = pass_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        timeout_d     = timeout_q;

        unique case (state_q)
            IDLE, DONE: begin
                // Auto-start only applies from IDLE; it is a one-shot per reset.
                if (start || (state_q == IDLE && auto_start_q)) begin
                    state_d       = RD_ID;
                    auto_start_d  = 1'b0;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_ID;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            RD_ID: begin
                if (!avm_waitrequest) begin
                    // Zero-latency slave: data is valid in the accept cycle,
                    // and the timestamp read follows with no idle cycle.
                    id_value_d    = avm_readdata;
                    id_ok_d       = id_match;
                    state_d       = RD_TS;
                    avm_address_d = SYSID_ADDR_TS;
                end else if (stall_limit_hit) begin
                    state_d       = DONE;
                    avm_read_d    = 1'b0;
                    avm_address_d = SYSID_ADDR_ID;
                    timeout_d     = 1'b1;
                    done_d        = 1'b1;
                    pass_d        = 1'b0;
                end
            end

            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d    = avm_readdata;
                    ts_ok_d       = ts_match;
                    pass_d        = id_ok_q && ts_match;
                    done_d        = 1'b1;
                    state_d       = DONE;
                    avm_read_d    = 1'b0;
                    avm_address_d = SYSID_ADDR_ID;
                end else if (stall_limit_hit) begin
                    state_d       = DONE;
                    avm_read_d    = 1'b0;
                    avm_address_d = SYSID_ADDR_ID;
                    timeout_d     = 1'b1;
                    done_d        = 1'b1;
                    pass_d        = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            auto_start_q  <= AUTO_START;
            avm_read_q    <= 1'b0;
            avm_address_q <= SYSID_ADDR_ID;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            auto_start_q  <= auto_start_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
            timeout_q     <= timeout_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = (state_q == RD_ID) || (state_q == RD_TS);
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
`ifdef SYSID_CHECK_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule : nios2_system_sysid_checker

// File: tb/tb_nios2_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_nios2_system_sysid_checker
//
// Directed bench for the system-ID checker with a zero-latency slave model.
// With SYSID_CHECK_TIMEOUT_EN defined, the stuck-waitrequest timeout scenario
// is also exercised (TIMEOUT_CYCLES = 8).
// -----------------------------------------------------------------------------
module tb_nios2_system_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'd0;
    localparam logic [31:0] GOOD_TS = 32'd1619612925;
    localparam logic [31:0] BAD_TS  = 32'h1234_5678;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        timeout;

    logic [31:0] slave_id;
    logic [31:0] slave_ts;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave model bookkeeping: total accepted reads and the last two addresses.
    int       read_total = 0;
    logic [1:0] addr_hist = 2'b00;

    nios2_system_sysid_checker #(
        .EXP_ID         (GOOD_ID),
        .EXP_TIMESTAMP  (GOOD_TS),
        .AUTO_START     (1'b1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .timeout         (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign avm_readdata = avm_address ? slave_ts : slave_id;

    always @(posedge clock) begin
        if (reset_n && avm_read && !avm_waitrequest) begin
            read_total <= read_total + 1;
            addr_hist  <= {addr_hist[0], avm_address};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " avm_read"},    32'(avm_read),    32'd0);
        chk({tag, " avm_address"}, 32'(avm_address), 32'd0);
        chk({tag, " busy"},        32'(busy),        32'd0);
        chk({tag, " done"},        32'(done),        32'd0);
        chk({tag, " pass"},        32'(pass),        32'd0);
        chk({tag, " id_ok"},       32'(id_ok),       32'd0);
        chk({tag, " ts_ok"},       32'(ts_ok),       32'd0);
        chk({tag, " id_value"},    id_value,         32'd0);
        chk({tag, " ts_value"},    ts_value,         32'd0);
        chk({tag, " timeout"},     32'(timeout),     32'd0);
    endtask

    initial begin
        int base;
        reset_n         = 1'b0;
        start           = 1'b0;
        avm_waitrequest = 1'b0;
        slave_id        = GOOD_ID;
        slave_ts        = GOOD_TS;

        // ---- Reset state ----
        step();
        chk_all_zero("reset");
        $display("txn reset: outputs checked under reset");

        // ---- Auto-start after reset release ----
        base    = read_total;
        reset_n = 1'b1;
        step();
        chk("auto rd_id read", 32'(avm_read), 32'd1);
        chk("auto rd_id addr", 32'(avm_address), 32'd0);
        chk("auto rd_id busy", 32'(busy), 32'd1);
        step();
        chk("auto rd_ts read", 32'(avm_read), 32'd1);
        chk("auto rd_ts addr", 32'(avm_address), 32'd1);
        step();
        chk("auto done", 32'(done), 32'd1);
        chk("auto pass", 32'(pass), 32'd1);
        chk("auto busy", 32'(busy), 32'd0);
        chk("auto read dropped", 32'(avm_read), 32'd0);
        chk("auto id_value", id_value, GOOD_ID);
        chk("auto ts_value", ts_value, GOOD_TS);
        chk("auto read count", 32'(read_total - base), 32'd2);
        chk("auto addr order", 32'(addr_hist), 32'd1);
        $display("txn auto-start: done=%0b pass=%0b id=%h ts=%h", done, pass, id_value, ts_value);

        // ---- Wrong timestamp ----
        slave_ts = BAD_TS;
        pulse_start();
        chk("badts done cleared", 32'(done), 32'd0);
        chk("badts pass cleared", 32'(pass), 32'd0);
        step();
        step();
        chk("badts done", 32'(done), 32'd1);
        chk("badts id_ok", 32'(id_ok), 32'd1);
        chk("badts ts_ok", 32'(ts_ok), 32'd0);
        chk("badts pass", 32'(pass), 32'd0);
        chk("badts ts_value", ts_value, BAD_TS);
        $display("txn bad-timestamp: id_ok=%0b ts_ok=%0b pass=%0b ts=%h", id_ok, ts_ok, pass, ts_value);

        // ---- Waitrequest held 3 cycles on the ID read ----
        slave_ts        = GOOD_TS;
        avm_waitrequest = 1'b1;
        base            = read_total;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d read", i), 32'(avm_read), 32'd1);
            chk($sformatf("stall%0d addr", i), 32'(avm_address), 32'd0);
            step();
        end
        avm_waitrequest = 1'b0;
        chk("stall release read", 32'(avm_read), 32'd1);
        chk("stall release addr", 32'(avm_address), 32'd0);
        chk("stall no early accept", 32'(read_total - base), 32'd0);
        step();
        chk("stall capture addr", 32'(avm_address), 32'd1);
        chk("stall capture count", 32'(read_total - base), 32'd1);
        step();
        chk("stall done", 32'(done), 32'd1);
        chk("stall pass", 32'(pass), 32'd1);
        $display("txn waitrequest-stall: done=%0b pass=%0b", done, pass);

        // ---- start while busy and on the completing cycle: ignored ----
        base = read_total;
        pulse_start();
        start = 1'b1;   // during RD_ID
        step();
        start = 1'b1;   // during RD_TS, coincides with completion
        step();
        start = 1'b0;
        chk("busy-start done", 32'(done), 32'd1);
        step();
        step();
        chk("busy-start still done", 32'(done), 32'd1);
        chk("busy-start no restart", 32'(avm_read), 32'd0);
        chk("busy-start read count", 32'(read_total - base), 32'd2);
        $display("txn start-while-busy: reads=%0d done=%0b", read_total - base, done);

        // ---- start in DONE triggers a fresh check ----
        base = read_total;
        pulse_start();
        chk("restart done cleared", 32'(done), 32'd0);
        chk("restart busy", 32'(busy), 32'd1);
        step();
        step();
        chk("restart done", 32'(done), 32'd1);
        chk("restart pass", 32'(pass), 32'd1);
        chk("restart read count", 32'(read_total - base), 32'd2);
        $display("txn restart-from-done: reads=%0d pass=%0b", read_total - base, pass);

        // ---- Reset asserted mid RD_TS ----
        pulse_start();
        step();
        chk("midreset in rd_ts", 32'(avm_address), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        chk("midreset rerun done", 32'(done), 32'd1);
        chk("midreset rerun pass", 32'(pass), 32'd1);
        chk("midreset rerun ts", ts_value, GOOD_TS);
        $display("txn reset-mid-read: rerun done=%0b pass=%0b", done, pass);

`ifdef SYSID_CHECK_TIMEOUT_EN
        // ---- Stuck waitrequest with timeout enabled ----
        begin
            int hi_cycles;
            hi_cycles       = 0;
            avm_waitrequest = 1'b1;
            pulse_start();
            for (int i = 0; i < 20; i++) begin
                if (!avm_read) break;
                hi_cycles++;
                step();
            end
            chk("timeout read cycles", 32'(hi_cycles), 32'd8);
            chk("timeout flag", 32'(timeout), 32'd1);
            chk("timeout done", 32'(done), 32'd1);
            chk("timeout pass", 32'(pass), 32'd0);
            chk("timeout id_ok", 32'(id_ok), 32'd0);
            avm_waitrequest = 1'b0;
            $display("txn timeout: read cycles=%0d timeout=%0b", hi_cycles, timeout);
        end
`else
        chk("timeout tied low", 32'(timeout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_nios2_system_sysid_checker
